// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator unit: opcode encodings and a small
// signed-overflow helper used by the arithmetic path.
package acc_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_INC  = 3'd4,
    OP_DEC  = 3'd5,
    OP_PUSH = 3'd6,
    OP_POP  = 3'd7
  } op_e;

  // Two's-complement overflow from the operand and result sign bits.
  function automatic logic signed_ovf(input logic a_s, input logic b_s,
                                      input logic r_s, input logic is_sub);
    if (is_sub) return (a_s != b_s) && (r_s != a_s);
    else        return (a_s == b_s) && (r_s != a_s);
  endfunction

endpackage

// File: rtl/acc_if.sv
// Command channel from the control unit into the accumulator: a qualified
// opcode plus its data operand.
interface acc_if
  import acc_pkg::*;
#(
  parameter int WIDTH = 24
);
  logic             op_valid;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] data_in;

  modport master (output op_valid, output op, output data_in);
  modport slave  (input  op_valid, input  op, input  data_in);
endinterface

// File: rtl/acc_lifo.sv
// Save/restore stack for the accumulator: storage, pointer, full/empty status,
// request acceptance and a one-cycle error pulse on overflow/underflow attempts.
module acc_lifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             pop_ok,
  output logic             full,
  output logic             empty,
  output logic             err
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [PW-1:0]    sp_q, sp_d;
  logic             err_q, err_d;
  logic             push_ok;
  logic [PW-1:0]    top_idx;

  assign full    = (sp_q == PW'(DEPTH));
  assign empty   = (sp_q == '0);
  assign push_ok = push_req && !full;
  assign pop_ok  = pop_req && !empty;
  assign top_idx = sp_q - PW'(1);
  assign rd_data = mem[top_idx[AW-1:0]];
  assign err     = err_q;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sp_d  = sp_q;
    err_d = (push_req && full) || (pop_req && empty);
    if (push_ok)     sp_d = sp_q + PW'(1);
    else if (pop_ok) sp_d = sp_q - PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; sp alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[sp_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/acc_unit.sv
// Parametrised datapath accumulator: load/add/sub/inc/dec with C/V/Z/N flags,
// tri-state bus drive and a LIFO for saving and restoring the accumulator.
module acc_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  acc_if.slave             cmd,
  input  logic             read_bus,
  output wire  [WIDTH-1:0] bus_out,
  output logic [WIDTH-1:0] alu_in,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             err
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             v_q, v_d;

  logic             cmd_go;
  op_e              op;
  logic             push_req, pop_req, pop_ok;
  logic [WIDTH-1:0] pop_data;
  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   add_r, sub_r;

  // clr takes priority, so a simultaneous op never reaches the stack or err.
  assign cmd_go   = cmd.op_valid && !clr;
  assign op       = op_e'(cmd.op);
  assign push_req = cmd_go && (op == OP_PUSH);
  assign pop_req  = cmd_go && (op == OP_POP);

  acc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk      (clk),
    .reset    (reset),
    .push_req (push_req),
    .pop_req  (pop_req),
    .wr_data  (acc_q),
    .rd_data  (pop_data),
    .pop_ok   (pop_ok),
    .full     (stack_full),
    .empty    (stack_empty),
    .err      (err)
  );

  // Carry out of the widened sum is C for add; the same bit of the widened
  // difference is the unsigned borrow for subtract.
  assign operand = (op == OP_INC || op == OP_DEC) ? WIDTH'(1) : cmd.data_in;
  assign add_r   = {1'b0, acc_q} + {1'b0, operand};
  assign sub_r   = {1'b0, acc_q} - {1'b0, operand};

  always_comb begin
    acc_d = acc_q;
    c_d   = c_q;
    v_d   = v_q;
    if (clr) begin
      acc_d = '0;
      c_d   = 1'b0;
      v_d   = 1'b0;
    end else if (cmd.op_valid) begin
      unique case (op)
        OP_LOAD: begin
          acc_d = cmd.data_in;
          c_d   = 1'b0;
          v_d   = 1'b0;
        end
        OP_ADD, OP_INC: begin
          acc_d = add_r[WIDTH-1:0];
          c_d   = add_r[WIDTH];
          v_d   = signed_ovf(acc_q[WIDTH-1], operand[WIDTH-1], add_r[WIDTH-1], 1'b0);
        end
        OP_SUB, OP_DEC: begin
          acc_d = sub_r[WIDTH-1:0];
          c_d   = sub_r[WIDTH];
          v_d   = signed_ovf(acc_q[WIDTH-1], operand[WIDTH-1], sub_r[WIDTH-1], 1'b1);
        end
        OP_POP: begin
          if (pop_ok) begin
            acc_d = pop_data;
            c_d   = 1'b0;
            v_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      c_q   <= c_d;
      v_q   <= v_d;
    end
  end

  assign alu_in  = acc_q;
  assign flag_z  = (acc_q == '0);
  assign flag_n  = acc_q[WIDTH-1];
  assign flag_c  = c_q;
  assign flag_v  = v_q;
  assign bus_out = read_bus ? acc_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit (WIDTH=24, DEPTH=4): a vector table for the
// op sequences plus hand-written bus and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_acc_unit;
  import acc_pkg::*;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          clr;
  logic          read_bus;
  wire  [W-1:0]  bus_out;
  logic [W-1:0]  alu_in;
  logic          flag_z, flag_n, flag_c, flag_v;
  logic          stack_full, stack_empty, err;

  int n_tests = 0;
  int n_fail  = 0;

  acc_if #(.WIDTH(W)) cmd_if ();

  acc_unit #(.WIDTH(W), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .cmd         (cmd_if.slave),
    .read_bus    (read_bus),
    .bus_out     (bus_out),
    .alu_in      (alu_in),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_c      (flag_c),
    .flag_v      (flag_v),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    string        name;
    logic         clr;
    logic         vld;
    logic [2:0]   op;
    logic [W-1:0] din;
    logic [W-1:0] acc;
    logic         z, n, c, v, e, full, empty;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Undriven bus: all-Z in a 4-state simulator, zero where the tool resolves
  // an undriven net to 0. Only called while acc is known nonzero.
  task automatic check_hiz(input string name);
    n_tests++;
    if (!((bus_out === {W{1'bz}}) || (bus_out === {W{1'b0}}))) begin
      n_fail++;
      $display("FAIL %s: bus_out got 0x%0h expected all-Z", name, bus_out);
    end
  endtask

  task automatic drive(input logic c, input logic vld, input logic [2:0] op, input logic [W-1:0] din);
    clr              = c;
    cmd_if.op_valid  = vld;
    cmd_if.op        = op;
    cmd_if.data_in   = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string nm, input logic c, input logic vld, input logic [2:0] op,
                     input logic [W-1:0] din, input logic [W-1:0] acc,
                     input logic z, input logic n, input logic cf, input logic v,
                     input logic e, input logic full, input logic empty);
    vec_t t;
    t.name = nm; t.clr = c; t.vld = vld; t.op = op; t.din = din; t.acc = acc;
    t.z = z; t.n = n; t.c = cf; t.v = v; t.e = e; t.full = full; t.empty = empty;
    vecs.push_back(t);
  endtask

  task automatic check_vec(input vec_t t);
    check({t.name, ".acc"},   32'(alu_in),      32'(t.acc));
    check({t.name, ".z"},     32'(flag_z),      32'(t.z));
    check({t.name, ".n"},     32'(flag_n),      32'(t.n));
    check({t.name, ".c"},     32'(flag_c),      32'(t.c));
    check({t.name, ".v"},     32'(flag_v),      32'(t.v));
    check({t.name, ".err"},   32'(err),         32'(t.e));
    check({t.name, ".full"},  32'(stack_full),  32'(t.full));
    check({t.name, ".empty"}, 32'(stack_empty), 32'(t.empty));
  endtask

  initial begin
    //   name         clr vld op       din        acc        z n c v e F E
    add("ld_ff",      0, 1, OP_LOAD, 24'hFFFFFF, 24'hFFFFFF, 0,1,0,0,0,0,1);
    add("inc_wrap",   0, 1, OP_INC,  24'h000000, 24'h000000, 1,0,1,0,0,0,1);
    add("ld_7f",      0, 1, OP_LOAD, 24'h7FFFFF, 24'h7FFFFF, 0,0,0,0,0,0,1);
    add("inc_ovf",    0, 1, OP_INC,  24'h000000, 24'h800000, 0,1,0,1,0,0,1);
    add("sub_ovf",    0, 1, OP_SUB,  24'h000001, 24'h7FFFFF, 0,0,0,1,0,0,1);
    add("ld_11",      0, 1, OP_LOAD, 24'h000011, 24'h000011, 0,0,0,0,0,0,1);
    add("push1",      0, 1, OP_PUSH, 24'h000000, 24'h000011, 0,0,0,0,0,0,0);
    add("ld_22",      0, 1, OP_LOAD, 24'h000022, 24'h000022, 0,0,0,0,0,0,0);
    add("push2",      0, 1, OP_PUSH, 24'h000000, 24'h000022, 0,0,0,0,0,0,0);
    add("ld_33",      0, 1, OP_LOAD, 24'h000033, 24'h000033, 0,0,0,0,0,0,0);
    add("push3",      0, 1, OP_PUSH, 24'h000000, 24'h000033, 0,0,0,0,0,0,0);
    add("ld_44",      0, 1, OP_LOAD, 24'h000044, 24'h000044, 0,0,0,0,0,0,0);
    add("push4",      0, 1, OP_PUSH, 24'h000000, 24'h000044, 0,0,0,0,0,1,0);
    add("push_full",  0, 1, OP_PUSH, 24'h000000, 24'h000044, 0,0,0,0,1,1,0);
    add("idle1",      0, 0, OP_ADD,  24'h000123, 24'h000044, 0,0,0,0,0,1,0);
    add("pop1",       0, 1, OP_POP,  24'h000000, 24'h000044, 0,0,0,0,0,0,0);
    add("pop2",       0, 1, OP_POP,  24'h000000, 24'h000033, 0,0,0,0,0,0,0);
    add("pop3",       0, 1, OP_POP,  24'h000000, 24'h000022, 0,0,0,0,0,0,0);
    add("pop4",       0, 1, OP_POP,  24'h000000, 24'h000011, 0,0,0,0,0,0,1);
    add("pop_empty",  0, 1, OP_POP,  24'h000000, 24'h000011, 0,0,0,0,1,0,1);
    add("idle2",      0, 1, OP_NOP,  24'h000000, 24'h000011, 0,0,0,0,0,0,1);
    add("ld_0",       0, 1, OP_LOAD, 24'h000000, 24'h000000, 1,0,0,0,0,0,1);
    add("dec_wrap",   0, 1, OP_DEC,  24'h000000, 24'hFFFFFF, 0,1,1,0,0,0,1);
    add("add_wrap",   0, 1, OP_ADD,  24'h000001, 24'h000000, 1,0,1,0,0,0,1);
    add("sub_plain",  0, 1, OP_SUB,  24'h000000, 24'h000000, 1,0,0,0,0,0,1);
    add("ld_66",      0, 1, OP_LOAD, 24'h000066, 24'h000066, 0,0,0,0,0,0,1);
    add("push_66",    0, 1, OP_PUSH, 24'h000000, 24'h000066, 0,0,0,0,0,0,0);
    add("ld_77",      0, 1, OP_LOAD, 24'h000077, 24'h000077, 0,0,0,0,0,0,0);
    add("push_77",    0, 1, OP_PUSH, 24'h000000, 24'h000077, 0,0,0,0,0,0,0);
    add("ld_56",      0, 1, OP_LOAD, 24'h000056, 24'h000056, 0,0,0,0,0,0,0);
    add("add_to_55",  0, 1, OP_ADD,  24'hFFFFFF, 24'h000055, 0,0,1,0,0,0,0);
    add("clr_vs_add", 1, 1, OP_ADD,  24'h000010, 24'h000000, 1,0,0,0,0,0,0);
    add("pop_77",     0, 1, OP_POP,  24'h000000, 24'h000077, 0,0,0,0,0,0,0);
    add("pop_66",     0, 1, OP_POP,  24'h000000, 24'h000066, 0,0,0,0,0,0,1);
    add("clr_empty",  1, 1, OP_POP,  24'h000000, 24'h000000, 1,0,0,0,0,0,1);

    reset    = 1'b1;
    read_bus = 1'b0;
    drive(0, 0, OP_NOP, '0);
    #12;
    check("rst.acc",   32'(alu_in),      32'h0);
    check("rst.z",     32'(flag_z),      32'h1);
    check("rst.empty", 32'(stack_empty), 32'h1);
    check("rst.full",  32'(stack_full),  32'h0);
    check("rst.err",   32'(err),         32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].vld, vecs[i].op, vecs[i].din);
      step();
      check_vec(vecs[i]);
    end

    // Bus: tri-state output follows read_bus combinationally.
    drive(0, 1, OP_LOAD, 24'hA5A5A5);
    step();
    drive(0, 0, OP_NOP, '0);
    check("bus.alu_in0", 32'(alu_in), 32'hA5A5A5);
    check_hiz("bus.off0");
    read_bus = 1'b1;
    #1;
    check("bus.on",      32'(bus_out), 32'hA5A5A5);
    check("bus.alu_in1", 32'(alu_in),  32'hA5A5A5);
    step();
    check("bus.on_held", 32'(bus_out), 32'hA5A5A5);
    read_bus = 1'b0;
    #1;
    check_hiz("bus.off1");
    check("bus.alu_in2", 32'(alu_in), 32'hA5A5A5);

    // Asynchronous reset mid-cycle with two entries stacked.
    drive(0, 1, OP_PUSH, '0);
    step();
    drive(0, 1, OP_LOAD, 24'h000123);
    step();
    drive(0, 1, OP_PUSH, '0);
    step();
    check("arst.pre_empty", 32'(stack_empty), 32'h0);
    check("arst.pre_acc",   32'(alu_in),      32'h000123);
    drive(0, 1, OP_ADD, 24'h000001);
    #2;
    reset = 1'b1;
    #1;
    check("arst.acc",   32'(alu_in),      32'h0);
    check("arst.z",     32'(flag_z),      32'h1);
    check("arst.empty", 32'(stack_empty), 32'h0 + 32'h1);
    check("arst.c",     32'(flag_c),      32'h0);
    step();
    check("arst.hold_acc", 32'(alu_in), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1, OP_POP, '0);
    step();
    drive(0, 0, OP_NOP, '0);
    check("arst.pop_err", 32'(err),         32'h1);
    check("arst.pop_acc", 32'(alu_in),      32'h0);
    check("arst.pop_emp", 32'(stack_empty), 32'h1);
    step();
    check("arst.err_clr", 32'(err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_unit.md
Name: acc_unit

Overview:
- Parametrised accumulator for the datapath; successor to the fixed 24-bit load-only accumulator.
- Holds the ALU operand/result register and adds these on-register operations: load, add, subtract, increment and decrement.
- Produces status flags and drives the shared bus through a tri-state output.
- Includes a small LIFO save/restore stack so the control unit can preserve the accumulator across subroutine-style sequences.

Parameters:
- WIDTH, 24, data width of the accumulator, bus and stack entries.
- DEPTH, 4, number of LIFO entries (>=1); pointer width is clog2(DEPTH+1).

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- clr  input  1  synchronous clear of accumulator and C/V flags; stack is untouched.
- op_valid  input  1  qualifies op; when low the cycle is a NOP.
- op  input  3  operation code (encodings in package).
- data_in  input  WIDTH  operand for LOAD/ADD/SUB.
- read_bus  input  1  drive bus_out when high.
- bus_out  output  WIDTH  accumulator value when read_bus=1, else all-Z.
- alu_in  output  WIDTH  accumulator value, always driven.
- flag_z  output  1  accumulator == 0 (combinational from register).
- flag_n  output  1  accumulator MSB (combinational from register).
- flag_c  output  1  registered carry/borrow.
- flag_v  output  1  registered signed overflow.
- stack_full  output  1  stack holds DEPTH entries.
- stack_empty  output  1  stack holds 0 entries.
- err  output  1  one-cycle pulse on an illegal push or pop.

Behaviour:
- Reset (async, any time including mid-operation): acc=0, C=V=0, stack pointer=0, err=0. Outputs settle to flag_z=1, flag_n=0, stack_empty=1, stack_full=0, bus_out=Z unless read_bus is high. Stack RAM contents are don't-care.
- Latency: an op sampled at edge k is visible on alu_in, bus_out and the flags after edge k. No multi-cycle ops; accepts one op per cycle.
- Priority: reset > clr > op_valid. When clr and op_valid are both high, clr wins, the op is dropped and err stays 0.
- Ops (applied when op_valid=1):
  - NOP: nothing changes.
  - LOAD: acc=data_in; C=V=0.
  - ADD: {C,acc}=acc+data_in; V=signed overflow.
  - SUB: acc=acc-data_in; C=1 on unsigned borrow (acc<data_in); V=signed overflow.
  - INC: acc+1, with C and V as for ADD.
  - DEC: acc-1, with C and V as for SUB.
  - PUSH: stack[sp]=acc; sp++. acc and flags are unchanged.
  - POP: sp--; acc=stack[sp-1]; C=V=0.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- PUSH when full, or POP when empty: the op is ignored (acc, flags and sp unchanged) and err=1 for exactly one cycle.
- err is 0 in every other cycle.
- The stack pointer never wraps.
- stack_full and stack_empty are derived from the registered sp.
- bus_out uses the tri-state idiom; read_bus is purely combinational with no registered enable.
- clr does not affect sp or stack contents.

Decomposition:
- Package acc_pkg holds the op encodings: NOP=0, LOAD=1, ADD=2, SUB=3, INC=4, DEC=5, PUSH=6, POP=7.
- Package acc_pkg also holds the op width constant, OP_W=3.
- Sub-module acc_lifo (WIDTH, DEPTH) contains the storage array, sp, the full/empty logic and the push/pop acceptance and err generation.
- acc_unit instantiates acc_lifo and keeps the arithmetic and flags.

Test Plan (WIDTH=24, DEPTH=4):
1. LOAD 0xFFFFFF, then INC -> acc=0x000000, Z=1, C=1, V=0, N=0.
2. LOAD 0x7FFFFF, then INC -> acc=0x800000, N=1, V=1, C=0. Then SUB 0x000001 -> acc=0x7FFFFF, V=1, C=0.
3. LOAD and PUSH 0x11, 0x22, 0x33, 0x44 -> stack_full=1. A fifth PUSH -> err pulses one cycle and sp is unchanged. Four POPs -> acc sequence 0x44, 0x33, 0x22, 0x11, then stack_empty=1. A fifth POP -> err=1 and acc stays 0x11.
4. Bus: read_bus=0 -> bus_out all-Z. read_bus=1 with acc=0xA5A5A5 -> bus_out=0xA5A5A5 in the same cycle, while alu_in=0xA5A5A5 throughout.
5. clr and op_valid (ADD 0x10) in the same cycle, with acc=0x55 and two entries stacked -> acc=0, C=V=0, err=0, and sp still 2.
6. Assert reset between clock edges after pushing two entries -> acc=0, stack_empty=1 and flag_z=1 immediately, before the next edge. After release, a POP gives err=1.
